m92_obj_dma: RTL
================

Name: m92_obj_dma

Overview:
- Sprite-list stage directly upstream of the sprite line renderer.
- Holds the CPU-visible sprite RAM: 256 objects × 4 words of 16 bits.
- On a CPU DMA request, waits for vertical blank, then copies the active sprite list into a 64-bit-wide render buffer.
- The renderer reads the render buffer by object index, and the DMA raises busy/IRQ status back to the CPU.

Parameters:
- OBJ_COUNT, 256: number of object slots; sets the CPU RAM depth (OBJ_COUNT*4 words) and the render buffer depth.
- IDX_W, 8: object index width, equal to log2(OBJ_COUNT).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  13.33 MHz clock enable; the DMA engine advances only when ce=1.
- vblank  in  1  high during vertical blank.
- cpu_addr  in  IDX_W+2  word address into sprite RAM.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  CPU read data; 1 clk latency.
- cpu_we  in  1  write strobe; the word is written on this clk.
- cpu_be  in  2  byte enables for cpu_we.
- list_len  in  IDX_W+1  number of active objects, range 0..OBJ_COUNT.
- dma_start  in  1  single-clk request pulse.
- dma_busy  out  1  high from an accepted request until the copy completes.
- dma_irq  out  1  one-clk pulse when a copy completes.
- rd_index  in  IDX_W  renderer object index.
- obj_data  out  64  object entry at rd_index; 1 clk latency.
- obj_valid  out  1  high when rd_index < latched length; same latency as obj_data.

Behaviour:
Reset values:
- dma_busy=0, dma_irq=0, obj_data=0, obj_valid=0, cpu_dout=0.
- Latched length = 0; FSM in IDLE.
- RAM contents are undefined after reset.

FSM states and transitions:
- IDLE: dma_start=1 → latch list_len into len_q, set dma_busy, go to WAIT_VBL.
- WAIT_VBL: when vblank=1 on a ce cycle → idx=0, word=0, go to COPY.
  - If len_q=0 on entry to COPY, go straight to DONE.
- COPY: on each ce cycle, read word idx*4+word from sprite RAM and shift it into the assembly register.
  - Word mapping: word0→[15:0], word1→[31:16], word2→[47:32], word3→[63:48].
  - RAM read latency is 1; the pipeline is permitted, but every entry is committed intact.
  - After word3 is captured, write the 64-bit entry into render buffer[idx], then idx++.
  - When idx reaches len_q-1 and that entry is written → go to DONE.
  - Copy time is 4*len_q ce cycles, plus at most 2 ce cycles of pipeline.
- DONE: clear dma_busy, pulse dma_irq for exactly one clk, go to IDLE.

Request and vblank handling:
- dma_start while dma_busy=1 is ignored: no restart and no re-latch.
- vblank falling mid-COPY does not pause or abort; the copy runs to completion.
- list_len changes after the request has no effect on an in-flight copy.
- list_len > OBJ_COUNT is clamped to OBJ_COUNT when latched.

CPU port:
- Always accessible, including during COPY.
- A CPU write to a word in the same cycle the DMA reads it: the DMA captures the pre-write value (read-before-write).
- cpu_be gates the bytes written: be[0]→[7:0], be[1]→[15:8].

Render port:
- Independent of ce.
- Registered outputs: obj_data = buffer[rd_index], obj_valid = (rd_index < len_q_done).
- len_q_done is updated to len_q only in DONE, so the renderer sees the new length together with the fully copied list.
- When obj_valid=0, obj_data is forced to 0.
- The render buffer is a single buffer. A read of an entry mid-COPY returns either the old or the new entry, never a mix.

Asynchronous reset mid-COPY:
- FSM returns to IDLE and busy clears.
- The partially written buffer is left as is; len_q_done=0, so all objects read invalid.

Decomposition:
- m92_pkg gains OBJ_WORDS=4, the object field bit positions (y[8:0], h[10:9], w[12:11], layer[15:13], code[31:16], color[38:32], pri[39], flipx[40], flipy[41], x[57:48]), and the FSM state enum obj_dma_state_t.
- One sub-module: m92_obj_dpram, a generic true-dual-port RAM (parameterised width and depth, byte enables on port A).
  - Instantiated twice: 16-bit CPU RAM and 64-bit render buffer.

Test Plan:
- Write objects 0..3 via CPU, list_len=4, dma_start with vblank=0 → busy=1 and no buffer write until vblank rises.
  - After vblank rises: irq after ≤18 ce cycles.
  - Read rd_index=2 → obj_data = {w3,w2,w1,w0} of object 2, obj_valid=1.
  - rd_index=4 → obj_valid=0, obj_data=0.
- list_len=0, dma_start, vblank=1 → dma_busy drops and dma_irq pulses within 3 ce cycles; all indices read invalid.
- list_len=300 → clamped to 256.
  - Copy takes 1024 ce cycles ±2; index 255 is valid.
- Second dma_start during COPY → ignored; exactly one irq pulse.
  - list_len changed mid-copy does not alter the copied count.
- CPU write of 16'hABCD to word 5 with be=2'b01, in the same cycle the DMA reads word 5 → buffer gets the old word; CPU RAM reads back low byte CD, high byte unchanged.
- Assert reset_n=0 mid-COPY at idx 10 → busy=0 immediately and all obj_valid=0.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/m92_pkg.sv
// Shared definitions for the M92 sprite-list DMA: object layout, word count and
// the DMA controller state encoding.
package m92_pkg;

  localparam int OBJ_WORDS = 4;

  // One render-buffer entry; word0 occupies [15:0] and word3 occupies [63:48].
  typedef struct packed {
    logic [5:0]  rsvd_hi;   // [63:58]
    logic [9:0]  x;         // [57:48]
    logic [5:0]  rsvd_mid;  // [47:42]
    logic        flipy;     // [41]
    logic        flipx;     // [40]
    logic        pri;       // [39]
    logic [6:0]  color;     // [38:32]
    logic [15:0] code;      // [31:16]
    logic [2:0]  layer;     // [15:13]
    logic [1:0]  w;         // [12:11]
    logic [1:0]  h;         // [10:9]
    logic [8:0]  y;         // [8:0]
  } obj_entry_t;

  typedef enum logic [1:0] {
    OBJ_IDLE,
    OBJ_WAIT_VBL,
    OBJ_COPY,
    OBJ_DONE
  } obj_dma_state_t;

endpackage

// File: rtl/m92_obj_dpram.sv
// Generic true-dual-port RAM with registered reads on both ports and byte
// enables on port A. A read and a write to the same word return the old data.
module m92_obj_dpram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_en,
  input  logic               a_we,
  input  logic [WIDTH/8-1:0] a_be,
  input  logic [AW-1:0]      a_addr,
  input  logic [WIDTH-1:0]   a_din,
  output logic [WIDTH-1:0]   a_dout,
  input  logic               b_en,
  input  logic               b_we,
  input  logic [AW-1:0]      b_addr,
  input  logic [WIDTH-1:0]   b_din,
  output logic [WIDTH-1:0]   b_dout
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en && a_we) begin
      for (int b = 0; b < NB; b++) begin
        if (a_be[b]) mem[a_addr][b*8 +: 8] <= a_din[b*8 +: 8];
      end
    end
    if (b_en && b_we) mem[b_addr] <= b_din;
  end

  // Read registers live in their own process so they always sample pre-write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      if (a_en) a_dout <= mem[a_addr];
      if (b_en) b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/m92_obj_dma.sv
// Sprite RAM plus vblank-synchronised DMA that assembles 4x16-bit object words
// into a 64-bit render buffer read by the sprite line renderer.
module m92_obj_dma
  import m92_pkg::*;
#(
  parameter int OBJ_COUNT = 256,
  parameter int IDX_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               vblank,
  input  logic [IDX_W+1:0]   cpu_addr,
  input  logic [15:0]        cpu_din,
  output logic [15:0]        cpu_dout,
  input  logic               cpu_we,
  input  logic [1:0]         cpu_be,
  input  logic [IDX_W:0]     list_len,
  input  logic               dma_start,
  output logic               dma_busy,
  output logic               dma_irq,
  input  logic [IDX_W-1:0]   rd_index,
  output logic [63:0]        obj_data,
  output logic               obj_valid
);

  localparam int WORD_W  = $clog2(OBJ_WORDS);
  localparam int WADDR_W = IDX_W + WORD_W;
  localparam int WCNT_W  = WADDR_W + 1;
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(OBJ_COUNT);

  obj_dma_state_t     state_reg, state_next;
  logic [IDX_W:0]     len_q_reg, len_done_reg, len_clamped;
  logic [WCNT_W-1:0]  rd_ptr_reg, cap_ptr_reg, word_total;
  logic               pend_reg;
  logic [47:0]        asm_reg;
  logic [15:0]        dma_word;
  obj_entry_t         entry;
  logic [63:0]        buf_q, buf_rd_unused;
  logic               obj_valid_reg;
  logic               issue, capture, commit, last_capture;

  assign len_clamped = (list_len > LEN_MAX) ? LEN_MAX : list_len;
  assign word_total  = {len_q_reg, WORD_W'(0)};
  assign entry       = obj_entry_t'({dma_word, asm_reg});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= OBJ_IDLE;
    else          state_reg <= state_next;
  end

  // Request acceptance and the DONE pulse are not ce-gated so a one-clk start
  // is never lost and the irq is exactly one clk wide.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OBJ_IDLE:     if (dma_start) state_next = OBJ_WAIT_VBL;
      OBJ_WAIT_VBL: if (ce && vblank) state_next = (len_q_reg == '0) ? OBJ_DONE : OBJ_COPY;
      OBJ_COPY:     if (last_capture) state_next = OBJ_DONE;
      OBJ_DONE:     state_next = OBJ_IDLE;
      default:      state_next = OBJ_IDLE;
    endcase
  end

  always_comb begin
    dma_busy     = (state_reg == OBJ_WAIT_VBL) || (state_reg == OBJ_COPY);
    dma_irq      = (state_reg == OBJ_DONE);
    issue        = 1'b0;
    capture      = 1'b0;
    if (state_reg == OBJ_COPY && ce) begin
      issue   = (rd_ptr_reg < word_total);
      capture = pend_reg;
    end
    commit       = capture && (cap_ptr_reg[WORD_W-1:0] == {WORD_W{1'b1}});
    last_capture = capture && (cap_ptr_reg == word_total - WCNT_W'(1));
  end

  // Reads run one ce cycle ahead of captures; word3 goes straight from the RAM
  // output into the buffer write so the entry lands in a single write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q_reg    <= '0;
      len_done_reg <= '0;
      rd_ptr_reg   <= '0;
      cap_ptr_reg  <= '0;
      pend_reg     <= 1'b0;
      asm_reg      <= '0;
    end else begin
      if (state_reg == OBJ_IDLE && dma_start) len_q_reg <= len_clamped;
      if (state_reg == OBJ_WAIT_VBL && ce && vblank) begin
        rd_ptr_reg  <= '0;
        cap_ptr_reg <= '0;
        pend_reg    <= 1'b0;
      end
      if (issue) rd_ptr_reg <= rd_ptr_reg + WCNT_W'(1);
      if (state_reg == OBJ_COPY && ce) pend_reg <= issue;
      if (capture) begin
        asm_reg     <= {dma_word, asm_reg[47:16]};
        cap_ptr_reg <= cap_ptr_reg + WCNT_W'(1);
      end
      if (state_reg == OBJ_DONE) len_done_reg <= len_q_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) obj_valid_reg <= 1'b0;
    else          obj_valid_reg <= ({1'b0, rd_index} < len_done_reg);
  end

  assign obj_valid = obj_valid_reg;
  assign obj_data  = obj_valid_reg ? buf_q : 64'h0;

  m92_obj_dpram #(
    .WIDTH (16),
    .DEPTH (OBJ_COUNT * OBJ_WORDS)
  ) u_cpu_ram (
    .clk    (clk),
    .rst_n  (reset_n),
    .a_en   (1'b1),
    .a_we   (cpu_we),
    .a_be   (cpu_be),
    .a_addr (cpu_addr),
    .a_din  (cpu_din),
    .a_dout (cpu_dout),
    .b_en   (ce),
    .b_we   (1'b0),
    .b_addr (rd_ptr_reg[WADDR_W-1:0]),
    .b_din  (16'h0),
    .b_dout (dma_word)
  );

  m92_obj_dpram #(
    .WIDTH (64),
    .DEPTH (OBJ_COUNT)
  ) u_render_buf (
    .clk    (clk),
    .rst_n  (reset_n),
    .a_en   (commit),
    .a_we   (commit),
    .a_be   (8'hFF),
    .a_addr (cap_ptr_reg[WADDR_W-1:WORD_W]),
    .a_din  (entry),
    .a_dout (buf_rd_unused),
    .b_en   (1'b1),
    .b_we   (1'b0),
    .b_addr (rd_index),
    .b_din  (64'h0),
    .b_dout (buf_q)
  );

endmodule
